// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter.
// Takes a WIDTH-bit word over a valid/ready handshake and sends it one bit at a
// time on sout. Each bit is held for BIT_CYCLES clocks. A new word can be taken in
// the last cycle of a frame, so back-to-back frames have no gap.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic             bit_end;
  logic             frame_end;

  // Frame boundary decode, taken from state and counters only
  always_comb begin
    bit_end   = (cyc_cnt == CYC_LAST);
    frame_end = (state == SHIFT) && (bit_cnt == BIT_LAST) && bit_end;
  end

  // din_ready does not depend on din_valid. Only IDLE or the last frame cycle may accept.
  assign din_ready = (state == IDLE) || frame_end;
  assign done      = frame_end;

  // shreg is all zero whenever the block is idle, so sout reads 0 there without a mux.
  assign sout       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign sout_valid = (state == SHIFT);
  assign busy       = sout_valid;

  // Control FSM, shift register and bit/cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            shreg   <= din;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (din_valid) begin
                shreg <= din;
              end else begin
                shreg <= '0;
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              if (MSB_FIRST != 0) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
              end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
              end
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          shreg   <= '0;
          bit_cnt <= '0;
          cyc_cnt <= '0;
        end
      endcase
    end
  end

endmodule
